// File: rtl/lsb_embedder.sv
// lsb_embedder: embeds a LEN_W-bit length header, then the message, into the two LSBs of
// successive cover bytes. One cover byte in gives one stego byte out. After the payload the
// block forwards cover bytes unmodified until reset.
// Optional feature: define YODA_XOR_SCRAMBLE_EN to XOR each payload symbol with XOR_KEY.
module lsb_embedder #(
    parameter int unsigned LEN_W   = 24,
    parameter logic [7:0]  XOR_KEY = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_msg_len_bits,
    input  logic [7:0]       i_cover_in,
    input  logic             i_cover_valid,
    output logic             o_cover_ready,
    input  logic [7:0]       i_msg_in,
    input  logic             i_msg_valid,
    output logic             o_msg_ready,
    output logic [7:0]       o_stego_out,
    output logic             o_stego_valid,
    input  logic             i_stego_ready,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned HdrN  = LEN_W / 2;
    localparam int unsigned HdrCw = (HdrN > 1) ? $clog2(HdrN) : 1;
    // One bit wider than LEN_W-3 so that ceil(len/8) fits even for len close to 2^LEN_W.
    localparam int unsigned ByteW = LEN_W - 2;

    typedef enum logic [1:0] {StIdle, StHeader, StPayload, StPass} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic             r_done;
    logic             w_done_next;

    logic [LEN_W-1:0] r_hdr_sh;
    logic [HdrCw-1:0] r_hdr_cnt;
    logic [ByteW-1:0] r_nbytes;
    logic [ByteW-1:0] r_bytes_loaded;
    logic [ByteW-1:0] r_bytes_sent;
    logic [7:0]       r_shreg;
    logic [2:0]       r_sym_cnt;
    logic [7:0]       r_stego;
    logic             r_stego_valid;

    logic             w_start_ok;
    logic [ByteW-1:0] w_nbytes_start;
    logic             w_out_free;
    logic             w_cover_accept;
    logic             w_msg_accept;
    logic             w_last_sym;
    logic             w_hdr_last;
    logic             w_pay_last;
    logic [1:0]       w_sym;
    logic [1:0]       w_key_sym;
    logic [7:0]       w_stego_next;

    assign w_start_ok     = i_start && (r_state == StIdle);
    assign w_nbytes_start = ByteW'(i_msg_len_bits[LEN_W-1:3]) + ByteW'(|i_msg_len_bits[2:0]);

    // Handshake decode for the cover, message and stego channels.
    always_comb begin
        w_out_free     = !r_stego_valid || i_stego_ready;
        // In PAYLOAD a cover byte is only taken when a message symbol is available.
        o_cover_ready  = (r_state != StIdle) && w_out_free &&
                         ((r_state != StPayload) || (r_sym_cnt != 3'd0));
        w_cover_accept = i_cover_valid && o_cover_ready;
        w_last_sym     = (r_state == StPayload) && w_cover_accept && (r_sym_cnt == 3'd1);
        // Reload allowed in the same cycle the 4th symbol leaves, so held msg_valid has no bubble.
        o_msg_ready    = (r_state == StPayload) && (r_bytes_loaded < r_nbytes) &&
                         ((r_sym_cnt == 3'd0) || w_last_sym);
        w_msg_accept   = i_msg_valid && o_msg_ready;
        w_hdr_last     = (r_state == StHeader) && w_cover_accept &&
                         (r_hdr_cnt == HdrCw'(HdrN - 1));
        w_pay_last     = w_last_sym && (r_bytes_sent == r_nbytes - ByteW'(1));
    end

`ifdef YODA_XOR_SCRAMBLE_EN
    // Key pair aligned with the symbol about to leave the shift register (MSB pair first).
    always_comb begin
        case (r_sym_cnt)
            3'd4:    w_key_sym = XOR_KEY[7:6];
            3'd3:    w_key_sym = XOR_KEY[5:4];
            3'd2:    w_key_sym = XOR_KEY[3:2];
            default: w_key_sym = XOR_KEY[1:0];
        endcase
    end
`else
    logic w_unused_key;
    assign w_unused_key = ^XOR_KEY;
    assign w_key_sym    = 2'b00;
`endif

    // Select the symbol to embed and form the next stego byte.
    always_comb begin
        w_sym = 2'b00;
        case (r_state)
            StHeader:  w_sym = r_hdr_sh[LEN_W-1 -: 2];
            StPayload: w_sym = r_shreg[7:6] ^ w_key_sym;
            default:   w_sym = 2'b00;
        endcase
        w_stego_next = (r_state == StPass) ? i_cover_in : {i_cover_in[7:2], w_sym};
    end

    // Next-state and done-pulse decode.
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_start_ok) w_state_next = StHeader;
            end
            StHeader: begin
                if (w_hdr_last) begin
                    if (r_nbytes != '0) begin
                        w_state_next = StPayload;
                    end else begin
                        w_state_next = StPass;
                        w_done_next  = 1'b1;
                    end
                end
            end
            StPayload: begin
                if (w_pay_last) begin
                    w_state_next = StPass;
                    w_done_next  = 1'b1;
                end
            end
            StPass:  w_state_next = StPass;
            default: w_state_next = StIdle;
        endcase
    end

    // State register and registered done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    // Length header shift register, header counter and byte total.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hdr_sh  <= '0;
            r_hdr_cnt <= '0;
            r_nbytes  <= '0;
        end else if (w_start_ok) begin
            r_hdr_sh  <= i_msg_len_bits;
            r_hdr_cnt <= '0;
            r_nbytes  <= w_nbytes_start;
        end else if ((r_state == StHeader) && w_cover_accept) begin
            r_hdr_sh  <= r_hdr_sh << 2;
            r_hdr_cnt <= r_hdr_cnt + HdrCw'(1);
        end
    end

    // Message shift register with symbol and byte bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg        <= '0;
            r_sym_cnt      <= '0;
            r_bytes_loaded <= '0;
            r_bytes_sent   <= '0;
        end else if (w_start_ok) begin
            r_shreg        <= '0;
            r_sym_cnt      <= '0;
            r_bytes_loaded <= '0;
            r_bytes_sent   <= '0;
        end else begin
            if (w_msg_accept) begin
                r_shreg        <= i_msg_in;
                r_sym_cnt      <= 3'd4;
                r_bytes_loaded <= r_bytes_loaded + ByteW'(1);
            end else if ((r_state == StPayload) && w_cover_accept) begin
                r_shreg   <= r_shreg << 2;
                r_sym_cnt <= r_sym_cnt - 3'd1;
            end
            if (w_last_sym) r_bytes_sent <= r_bytes_sent + ByteW'(1);
        end
    end

    // Single-stage output register; valid holds until the downstream handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stego       <= '0;
            r_stego_valid <= 1'b0;
        end else if (w_cover_accept) begin
            r_stego       <= w_stego_next;
            r_stego_valid <= 1'b1;
        end else if (i_stego_ready) begin
            r_stego_valid <= 1'b0;
        end
    end

    assign o_stego_out   = r_stego;
    assign o_stego_valid = r_stego_valid;
    assign o_busy        = (r_state == StHeader) || (r_state == StPayload);
    assign o_done        = r_done;

endmodule

// File: tb/tb_lsb_embedder.sv
// tb_lsb_embedder: table-driven and randomized bench for lsb_embedder with a symbol-list
// reference model. Honours YODA_XOR_SCRAMBLE_EN in the model.
module tb_lsb_embedder;

    localparam logic [7:0] KEY = 8'hA5;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic [23:0] i_msg_len_bits;
    logic [7:0]  i_cover_in;
    logic        i_cover_valid;
    logic        o_cover_ready;
    logic [7:0]  i_msg_in;
    logic        i_msg_valid;
    logic        o_msg_ready;
    logic [7:0]  o_stego_out;
    logic        o_stego_valid;
    logic        i_stego_ready;
    logic        o_busy;
    logic        o_done;

    lsb_embedder #(
        .LEN_W   (24),
        .XOR_KEY (KEY)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_start        (i_start),
        .i_msg_len_bits (i_msg_len_bits),
        .i_cover_in     (i_cover_in),
        .i_cover_valid  (i_cover_valid),
        .o_cover_ready  (o_cover_ready),
        .i_msg_in       (i_msg_in),
        .i_msg_valid    (i_msg_valid),
        .o_msg_ready    (o_msg_ready),
        .o_stego_out    (o_stego_out),
        .o_stego_valid  (o_stego_valid),
        .i_stego_ready  (i_stego_ready),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         len;
        int         extra;       // cover bytes beyond header+payload (PASS region)
        bit         rand_cov;
        logic [7:0] cov;
        logic [7:0] m0;
        logic [7:0] m1;
        int         rdy_mode;    // 0: ready=1, 1: toggle, 2: random ready and cover_valid
        int         gap;         // cycles msg_valid held low while msg_ready is high
        int         abort_at;    // accepted covers before an async reset (0: none)
        bit         hand;        // compare against hand-written byte list too
        int         exp_done_at; // accepted covers before done is seen
    } vec_t;

    int          n_checks;
    int          n_errors;
    logic [23:0] cur_len;
    int          nbytes_g;
    logic [7:0]  msg_buf [16];
    logic [7:0]  hand_exp [20];
    vec_t        vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected stego byte at output position idx: header symbols, then payload symbols, then
    // the cover byte unchanged.
    function automatic logic [7:0] model_byte(input int idx, input logic [7:0] cov);
        int         j;
        logic [1:0] sym;
        logic [7:0] mb;
        if (idx >= 12 + 4 * nbytes_g) return cov;
        if (idx < 12) begin
            sym = 2'((cur_len >> (22 - 2 * idx)) & 24'h3);
        end else begin
            j   = idx - 12;
            mb  = msg_buf[j / 4];
            sym = 2'((mb >> (6 - 2 * (j % 4))) & 8'h3);
`ifdef YODA_XOR_SCRAMBLE_EN
            sym = sym ^ 2'((KEY >> (6 - 2 * (j % 4))) & 8'h3);
`endif
        end
        return {cov[7:2], sym};
    endfunction

    task automatic run_vec(input vec_t v);
        int         nb;
        int         ncov;
        int         acc;
        int         outn;
        int         midx;
        int         cyc;
        int         done_n;
        int         done_at;
        int         gap_left;
        bit         saw_mr;
        bit         hold;
        bit         aborted;
        bit         pass_start_sent;
        logic [7:0] hold_val;
        logic [7:0] cur_cov;
        logic [7:0] exp;
        logic [7:0] cov_q [$];

        nb       = (v.len + 7) / 8;
        ncov     = 12 + 4 * nb + v.extra;
        cur_len  = 24'(v.len);
        nbytes_g = nb;
        msg_buf[0] = v.m0;
        msg_buf[1] = v.m1;
        for (int i = 2; i < 16; i++) msg_buf[i] = 8'($urandom);

        reset = 1'b1;
        i_start = 1'b0; i_msg_len_bits = '0; i_cover_in = '0; i_cover_valid = 1'b0;
        i_msg_in = '0; i_msg_valid = 1'b0; i_stego_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", {o_stego_valid, o_cover_ready, o_msg_ready, o_busy, o_done, o_stego_out},
            '0);
        reset = 1'b0;
        @(negedge clk);
        i_start = 1'b1;
        i_msg_len_bits = cur_len;
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 1);

        acc = 0; outn = 0; midx = 0; cyc = 0; done_n = 0; done_at = -1; gap_left = v.gap;
        saw_mr = 0; hold = 0; aborted = 0; pass_start_sent = 0; hold_val = '0;
        cur_cov = v.rand_cov ? 8'($urandom) : v.cov;

        while (!aborted && (acc < ncov || outn < ncov) && cyc < 3000) begin
            i_cover_in    = cur_cov;
            i_cover_valid = (acc < ncov) && (v.rdy_mode != 2 || $urandom_range(0, 3) != 0);
            i_msg_valid   = (midx < nb) && (gap_left == 0);
            i_msg_in      = msg_buf[midx % 16];
            case (v.rdy_mode)
                1:       i_stego_ready = (cyc % 2) == 1;
                2:       i_stego_ready = $urandom_range(0, 2) != 0;
                default: i_stego_ready = 1'b1;
            endcase
            // Starts issued while busy and while in PASS must be ignored.
            i_start = 1'b0;
            i_msg_len_bits = cur_len;
            if (cyc == 3 || (done_n > 0 && !pass_start_sent)) begin
                i_start = 1'b1;
                i_msg_len_bits = 24'hFFFFFF;
                if (done_n > 0) pass_start_sent = 1;
            end
            #1;
            if (o_msg_ready) saw_mr = 1;
            if (hold) chk("stego_hold", {o_stego_valid, o_stego_out}, {1'b1, hold_val});
            if (o_done) begin
                done_n++;
                done_at = acc;
            end
            if (gap_left > 0 && o_msg_ready) begin
                chk("gap_cover_ready", o_cover_ready, 0);
                if (gap_left < v.gap) chk("gap_no_stego", o_stego_valid, 0);
                gap_left--;
            end
            if (o_stego_valid && i_stego_ready) begin
                if (cov_q.size() == 0) begin
                    chk("stego_unexpected", 1, 0);
                end else begin
                    exp = model_byte(outn, cov_q.pop_front());
                    chk("stego_byte", o_stego_out, exp);
`ifndef YODA_XOR_SCRAMBLE_EN
                    if (v.hand && outn < 20) chk("stego_hand", o_stego_out, hand_exp[outn]);
`endif
                end
                outn++;
            end
            hold     = o_stego_valid && !i_stego_ready;
            hold_val = o_stego_out;
            if (i_cover_valid && o_cover_ready) begin
                cov_q.push_back(cur_cov);
                acc++;
                cur_cov = v.rand_cov ? 8'($urandom) : v.cov;
            end
            if (i_msg_valid && o_msg_ready) midx++;
            if (v.abort_at > 0 && acc >= v.abort_at) begin
                @(posedge clk);
                #2;
                reset = 1'b1;
                #1;
                chk("async_reset_clear",
                    {o_stego_valid, o_cover_ready, o_msg_ready, o_busy, o_done, o_stego_out}, '0);
                aborted = 1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end

        if (!aborted) begin
            chk("timeout", cyc < 3000, 1);
            chk("done_count", done_n, 1);
            chk("done_at", done_at, v.exp_done_at);
            chk("msgs_used", midx, nb);
            chk("msg_ready_seen", saw_mr, nb != 0);
            chk("busy_end", o_busy, 0);
        end
        i_cover_valid = 1'b0;
        i_msg_valid   = 1'b0;
        i_start       = 1'b0;
    endtask

    initial begin
        vec_t rv;
        int   rl;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;

        for (int i = 0; i < 9; i++) hand_exp[i] = 8'hFC;
        hand_exp[9]  = 8'hFD; hand_exp[10] = 8'hFC; hand_exp[11] = 8'hFC;
        hand_exp[12] = 8'hFF; hand_exp[13] = 8'hFC; hand_exp[14] = 8'hFD; hand_exp[15] = 8'hFE;
        hand_exp[16] = 8'hFD; hand_exp[17] = 8'hFD; hand_exp[18] = 8'hFE; hand_exp[19] = 8'hFE;

        //          len extra rnd cov    m0     m1     rdy gap abort hand done_at
        vecs[0] = '{16, 2,    0,  8'hFF, 8'hC6, 8'h5A, 0,  0,  0,    1,   20};
        vecs[1] = '{0,  2,    0,  8'h80, 8'h00, 8'h00, 0,  0,  0,    0,   12};
        vecs[2] = '{8,  2,    0,  8'h3C, 8'h9B, 8'h00, 0,  5,  0,    0,   16};
        vecs[3] = '{8,  3,    1,  8'h00, 8'hE4, 8'h00, 1,  0,  0,    0,   16};
        vecs[4] = '{8,  2,    0,  8'h55, 8'h71, 8'h00, 0,  0,  14,   0,   16};
        vecs[5] = '{8,  2,    0,  8'h33, 8'h2D, 8'h00, 0,  0,  0,    0,   16};
        vecs[6] = '{8,  1,    0,  8'h00, 8'h00, 8'h00, 0,  0,  0,    0,   16};
        vecs[7] = '{13, 2,    1,  8'h00, 8'hA7, 8'h3E, 2,  0,  0,    0,   20};

        for (int t = 0; t < 8; t++) run_vec(vecs[t]);

        for (int r = 0; r < 6; r++) begin
            rl = int'($urandom_range(0, 70));
            rv = '{rl, int'($urandom_range(0, 3)), 1, 8'h00, 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 2)), 0, 0, 0, 12 + 4 * ((rl + 7) / 8)};
            run_vec(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
